xor_fault_ctrl: RTL and testbench

Sequencer for the laser fault-injection XOR target. It drives the target's six data inputs and oscillator enable, and supports two modes. In locate mode it holds the clock-on-input emission condition for photon-emission imaging. In attack mode it steps through every input vector, fires a laser trigger, samples the target output, and counts mismatches against the expected parity. It sits between the host control logic and the XOR target's `a[5:0]`, `osc_en` and `q` pins.

---
 rtl/xor_fault_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_xor_fault_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fault_ctrl.sv
// Sequencer for the laser fault-injection XOR target: holds the emission
// condition in locate mode, or sweeps vectors, fires the laser and counts faults.
module xor_fault_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VECTORS   = 64,
    parameter int CNT_W         = 16
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_q,
    output logic [5:0]       dut_a,
    output logic             dut_osc_en,
    output logic             laser_trig,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [5:0]       first_fault_vec,
    output logic             first_fault_valid
);

    typedef enum logic [2:0] {
        IDLE,
        LOCATE,
        APPLY,
        FIRE,
        SAMPLE,
        NEXT,
        DONE
    } state_t;

    localparam logic [8:0] APPLY_LAST  = 9'(SETTLE_CYCLES - 1);
    localparam logic [8:0] SAMPLE_LAST = 9'(SETTLE_CYCLES + 1);
    localparam logic [5:0] VEC_LAST    = 6'(NUM_VECTORS - 1);

    state_t     state, next_state;
    logic [5:0] vec, vec_next;
    logic [8:0] settle_cnt, settle_next;
    logic       q_meta, q_sync;
    logic       start_ok, mismatch;

    logic [5:0] dut_a_d;
    logic       osc_en_d, trig_d, busy_d, done_d;

    assign start_ok = (state == IDLE) && start;

    // Abort wins over the compare on the final sample cycle.
    assign mismatch = (state == SAMPLE) && (settle_cnt == SAMPLE_LAST) && !abort
                      && (q_sync != (^vec));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 6'd0;
            settle_cnt <= 9'd0;
        end else begin
            state      <= next_state;
            vec        <= vec_next;
            settle_cnt <= settle_next;
        end
    end

    always_comb begin
        next_state  = state;
        vec_next    = vec;
        settle_next = settle_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (mode) begin
                        next_state = LOCATE;
                    end else begin
                        next_state  = APPLY;
                        vec_next    = 6'd0;
                        settle_next = 9'd0;
                    end
                end
            end
            LOCATE: begin
                if (abort) next_state = IDLE;
            end
            APPLY: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (settle_cnt == APPLY_LAST) begin
                    next_state  = FIRE;
                    settle_next = 9'd0;
                end else begin
                    settle_next = settle_cnt + 9'd1;
                end
            end
            FIRE: begin
                settle_next = 9'd0;
                next_state  = abort ? IDLE : SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (settle_cnt == SAMPLE_LAST) begin
                    next_state  = NEXT;
                    settle_next = 9'd0;
                end else begin
                    settle_next = settle_cnt + 9'd1;
                end
            end
            NEXT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (vec == VEC_LAST) begin
                    next_state = DONE;
                end else begin
                    next_state  = APPLY;
                    vec_next    = vec + 6'd1;
                    settle_next = 9'd0;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered.
    always_comb begin
        dut_a_d  = 6'd0;
        osc_en_d = 1'b0;
        trig_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (next_state)
            LOCATE: begin
                osc_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            APPLY, SAMPLE, NEXT: begin
                dut_a_d = vec_next;
                busy_d  = 1'b1;
            end
            FIRE: begin
                dut_a_d = vec_next;
                trig_d  = 1'b1;
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                dut_a_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            dut_a      <= 6'd0;
            dut_osc_en <= 1'b0;
            laser_trig <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dut_a      <= dut_a_d;
            dut_osc_en <= osc_en_d;
            laser_trig <= trig_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            q_meta <= dut_q;
            q_sync <= q_meta;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt         <= '0;
            first_fault_vec   <= 6'd0;
            first_fault_valid <= 1'b0;
        end else if (start_ok) begin
            fault_cnt         <= '0;
            first_fault_vec   <= 6'd0;
            first_fault_valid <= 1'b0;
        end else if (mismatch) begin
            if (fault_cnt != {CNT_W{1'b1}}) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
            if (!first_fault_valid) begin
                first_fault_vec   <= vec;
                first_fault_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xor_fault_ctrl.sv
// Scoreboard bench for xor_fault_ctrl: expected laser shots are queued at start
// and popped as each laser_trig appears; a CNT_W=4 copy checks saturation.
module tb_xor_fault_ctrl;

    localparam int S   = 4;
    localparam int N   = 64;
    localparam int PER = 2 * S + 4;

    typedef struct {
        logic [5:0] vec;
        int         cyc;
    } trig_exp_t;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic mode   = 1'b0;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic dut_q, sat_q;

    logic [5:0]  dut_a, sat_a;
    logic        dut_osc_en, laser_trig, busy, done;
    logic [15:0] fault_cnt;
    logic [5:0]  first_fault_vec;
    logic        first_fault_valid;
    logic        sat_osc_en, sat_trig, sat_busy, sat_done;
    logic [3:0]  sat_fault_cnt;
    logic [5:0]  sat_first_vec;
    logic        sat_first_valid;

    int inv_sel    = 0;
    int cycle_cnt  = 0;
    int trig_cnt   = 0;
    int done_cnt   = 0;
    int check_cnt  = 0;
    int error_cnt  = 0;
    int t_start    = 0;
    int trig_base  = 0;
    int done_base  = 0;
    int when_done  = 0;
    int abort_cyc  = 0;
    trig_exp_t exp_q[$];

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cycle_cnt <= cycle_cnt + 1;

    // Target model: ideal parity, optionally inverted for selected vectors.
    function automatic logic flip(input logic [5:0] v, input int sel);
        case (sel)
            1:       return (v == 6'h2A) || (v == 6'h30);
            2:       return (v == 6'd5) || (v == 6'd10);
            default: return 1'b0;
        endcase
    endfunction

    assign dut_q = (^dut_a) ^ flip(dut_a, inv_sel);
    assign sat_q = !(^sat_a);

    xor_fault_ctrl u_dut (
        .sysclk            (sysclk),
        .rst_n             (rst_n),
        .mode              (mode),
        .start             (start),
        .abort             (abort),
        .dut_q             (dut_q),
        .dut_a             (dut_a),
        .dut_osc_en        (dut_osc_en),
        .laser_trig        (laser_trig),
        .busy              (busy),
        .done              (done),
        .fault_cnt         (fault_cnt),
        .first_fault_vec   (first_fault_vec),
        .first_fault_valid (first_fault_valid)
    );

    xor_fault_ctrl #(.CNT_W(4)) u_dut_sat (
        .sysclk            (sysclk),
        .rst_n             (rst_n),
        .mode              (mode),
        .start             (start),
        .abort             (abort),
        .dut_q             (sat_q),
        .dut_a             (sat_a),
        .dut_osc_en        (sat_osc_en),
        .laser_trig        (sat_trig),
        .busy              (sat_busy),
        .done              (sat_done),
        .fault_cnt         (sat_fault_cnt),
        .first_fault_vec   (sat_first_vec),
        .first_fault_valid (sat_first_valid)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle_cnt);
        end
    endtask

    function automatic logic [63:0] outs_main();
        return {31'd0, dut_a, dut_osc_en, laser_trig, busy, done,
                fault_cnt, first_fault_vec, first_fault_valid};
    endfunction

    function automatic logic [63:0] outs_sat();
        return {43'd0, sat_a, sat_osc_en, sat_trig, sat_busy, sat_done,
                sat_fault_cnt, sat_first_vec, sat_first_valid};
    endfunction

    // Pulse start for one cycle; attack runs queue every expected laser shot.
    task automatic applyStimulus(input logic m);
        @(negedge sysclk);
        mode      = m;
        start     = 1'b1;
        t_start   = cycle_cnt;
        trig_base = trig_cnt;
        if (!m) begin
            for (int v = 0; v < N; v++) begin
                trig_exp_t e;
                e.vec = 6'(v);
                e.cyc = t_start + 1 + v * PER + S;
                exp_q.push_back(e);
            end
        end
        @(negedge sysclk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int when);
        when = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (done) begin
                when = cycle_cnt;
                break;
            end
        end
        if (when < 0) checkOutput("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic waitUntil(input int c);
        while (cycle_cnt < c) @(negedge sysclk);
    endtask

    always @(negedge sysclk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (laser_trig) begin
            trig_cnt <= trig_cnt + 1;
            if (exp_q.size() == 0) begin
                checkOutput("trig_unexpected", {63'd0, laser_trig}, 64'd0);
            end else begin
                checkOutput("trig_vec", {58'd0, dut_a}, {58'd0, exp_q[0].vec});
                checkOutput("trig_cycle", 64'(cycle_cnt), 64'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        $display("[TB] reset with random inputs");
        mode  = 1'($urandom);
        start = 1'($urandom);
        abort = 1'($urandom);
        repeat (5) @(negedge sysclk);
        checkOutput("reset_outs", outs_main(), 64'd0);
        checkOutput("reset_outs_sat", outs_sat(), 64'd0);
        mode  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            checkOutput("idle_outs", outs_main(), 64'd0);
        end

        $display("[TB] attack run, ideal target");
        inv_sel = 0;
        applyStimulus(1'b0);
        waitDone(when_done);
        checkOutput("done_cycle", 64'(when_done), 64'(t_start + 1 + N * PER));
        checkOutput("trig_count", 64'(trig_cnt - trig_base), 64'(N));
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        checkOutput("dut_a_at_done", {58'd0, dut_a}, 64'd0);
        checkOutput("fault_cnt_ideal", {48'd0, fault_cnt}, 64'd0);
        checkOutput("first_valid_ideal", {63'd0, first_fault_valid}, 64'd0);
        checkOutput("sat_fault_cnt", {60'd0, sat_fault_cnt}, 64'd15);
        checkOutput("sat_first_vec", {58'd0, sat_first_vec}, 64'd0);
        checkOutput("sat_first_valid", {63'd0, sat_first_valid}, 64'd1);

        $display("[TB] attack run, faults at 0x2A and 0x30");
        inv_sel = 1;
        applyStimulus(1'b0);
        waitDone(when_done);
        checkOutput("done_cycle_2", 64'(when_done), 64'(t_start + 1 + N * PER));
        checkOutput("fault_cnt_two", {48'd0, fault_cnt}, 64'd2);
        checkOutput("first_vec_two", {58'd0, first_fault_vec}, 64'h2A);
        checkOutput("first_valid_two", {63'd0, first_fault_valid}, 64'd1);

        $display("[TB] restart clears results, mid-run start, abort in last sample cycle");
        inv_sel = 2;
        applyStimulus(1'b0);
        checkOutput("restart_cnt_clr", {48'd0, fault_cnt}, 64'd0);
        checkOutput("restart_vec_clr", {58'd0, first_fault_vec}, 64'd0);
        checkOutput("restart_valid_clr", {63'd0, first_fault_valid}, 64'd0);
        waitUntil(t_start + 100);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        checkOutput("midrun_start_busy", {63'd0, busy}, 64'd1);
        checkOutput("midrun_start_cnt", {48'd0, fault_cnt}, 64'd1);
        waitUntil(t_start + 1 + 10 * PER + S + 1 + S + 1);
        abort = 1'b1;
        @(negedge sysclk);
        abort = 1'b0;
        exp_q.delete();
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_dut_a", {58'd0, dut_a}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_fault_cnt", {48'd0, fault_cnt}, 64'd1);
        checkOutput("abort_first_vec", {58'd0, first_fault_vec}, 64'd5);
        checkOutput("abort_first_valid", {63'd0, first_fault_valid}, 64'd1);
        done_base = done_cnt;
        repeat (20) @(negedge sysclk);
        checkOutput("abort_no_done", 64'(done_cnt), 64'(done_base));

        $display("[TB] locate mode");
        applyStimulus(1'b1);
        for (int i = 0; i < 500; i++) begin
            checkOutput("locate_outs", {56'd0, dut_osc_en, dut_a, busy}, 64'h81);
            @(negedge sysclk);
        end
        abort     = 1'b1;
        abort_cyc = cycle_cnt;
        @(negedge sysclk);
        abort = 1'b0;
        mode  = 1'b0;
        checkOutput("locate_abort_cycle", 64'(cycle_cnt), 64'(abort_cyc + 1));
        checkOutput("locate_abort_osc", {63'd0, dut_osc_en}, 64'd0);
        checkOutput("locate_abort_busy", {63'd0, busy}, 64'd0);
        done_base = done_cnt;
        repeat (20) @(negedge sysclk);
        checkOutput("locate_no_done", 64'(done_cnt), 64'(done_base));

        $display("[TB] reset pulsed mid-run");
        inv_sel = 2;
        applyStimulus(1'b0);
        waitUntil(t_start + 75);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outs", outs_main(), 64'd0);
        checkOutput("midrun_reset_outs_sat", outs_sat(), 64'd0);
        exp_q.delete();
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        checkOutput("post_reset_outs", outs_main(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
